mux8_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares the 8:1 single-bit select mux between eight requesters.
- It owns the 3-bit select and grants one requester at a time for a bounded burst.
- Each granted cycle registers the selected data bit into an output stage.
- It sits between the per-channel request sources and the downstream serial bit consumer, and is the only driver of the mux select in the design.

---
 rtl/mux8_rr_scheduler.sv | 75 +++++++
 tb/tb_mux8_rr_scheduler.sv | 118 +++++++++++
 2 files changed

// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler: round-robin owner of the 8:1 bit-mux select, granting bounded bursts
//   clk               : rising-edge system clock
//   rst_n             : asynchronous active-low reset
//   req[7:0]          : per-channel request, bit i = channel i wants the lane
//   in[7:0]           : per-channel data bits feeding the mux
//   sel[2:0]          : registered mux select, current or most recent grant
//   gnt[7:0]          : one-hot grant, zero when idle
//   busy              : high while a channel is granted
//   out_bit/out_valid : registered in[sel] and its one-cycle strobe per transfer
module mux8_rr_scheduler #(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] in,
   output logic [2:0] sel,
   output logic [7:0] gnt,
   output logic       busy,
   output logic       out_bit,
   output logic       out_valid
);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;
   logic [0:0]       state_q, state_d;
   logic [2:0]       sel_q, sel_d, ptr_q, ptr_d, nxt;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
   logic             out_bit_q, out_bit_d, out_valid_q, out_valid_d;
   logic             xfer, rel, repick;
   // First requesting channel at or after s, wrapping 7->0; descending scan so the lowest offset wins.
   function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] s);
      logic [2:0] p;
      p = s;
      for (int i = 7; i >= 0; i--)
         if (r[s + 3'(i)]) p = s + 3'(i);
      return p;
   endfunction
   always_comb begin
      xfer        = state_q == GRANT && req[sel_q];
      cnt_nx      = cnt_q + CNT_W'(1);
      rel         = state_q == GRANT && (!xfer || cnt_nx == CNT_W'(MAX_BURST));
      repick      = state_q == IDLE || rel;
      // On release the old grant is scanned last, which is what makes the rotation fair.
      nxt         = pick(req, state_q == GRANT ? sel_q + 3'd1 : ptr_q);
      state_d     = ((state_q == GRANT && !rel) || |req) ? GRANT : IDLE;
      sel_d       = (repick && |req) ? nxt : sel_q;
      cnt_d       = repick ? '0 : cnt_nx;
      ptr_d       = rel ? sel_q + 3'd1 : ptr_q;
      out_bit_d   = xfer ? in[sel_q] : out_bit_q;
      out_valid_d = xfer;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         out_bit_q   <= out_bit_d;
         out_valid_q <= out_valid_d;
      end
   end
   assign busy      = state_q == GRANT;
   assign sel       = sel_q;
   assign gnt       = busy ? 8'(1) << sel_q : '0;
   assign out_bit   = out_bit_q;
   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// tb_mux8_rr_scheduler: randomized scoreboard bench for mux8_rr_scheduler against a behavioural model
module tb_mux8_rr_scheduler;
   localparam int MB = 4;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = '0;
   logic [7:0] din = '0;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       busy, out_bit, out_valid;
   logic [13:0] exp_q[$];
   int n_pass = 0;
   int n_total = 0;
   mux8_rr_scheduler #(.MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .in(din),
      .sel(sel), .gnt(gnt), .busy(busy), .out_bit(out_bit), .out_valid(out_valid)
   );
   always #5 clk = ~clk;
   function automatic int find_from(input logic [7:0] r, input int s);
      for (int k = 0; k < 8; k++)
         if (r[(s + k) % 8]) return (s + k) % 8;
      return -1;
   endfunction
   // Reference model: tracks owner, transfers so far and rotation start as plain integers.
   initial begin
      int owner, done, start, last_sel, ob, ov, p;
      bit active, release_now;
      owner = 0; done = 0; start = 0; last_sel = 0; ob = 0; ov = 0; active = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            active = 0; done = 0; start = 0; last_sel = 0; ob = 0; ov = 0;
         end else if (!active) begin
            ov = 0;
            p = find_from(req, start);
            if (p >= 0) begin active = 1; owner = p; last_sel = p; done = 0; end
         end else begin
            release_now = 0;
            if (req[owner]) begin
               ob = din[owner]; ov = 1; done++;
               if (done == MB) release_now = 1;
            end else begin
               ov = 0; release_now = 1;
            end
            if (release_now) begin
               start = (owner + 1) % 8;
               p = find_from(req, start);
               if (p >= 0) begin owner = p; last_sel = p; done = 0; end
               else active = 0;
            end
         end
         exp_q.push_back({3'(last_sel), active ? 8'(1 << last_sel) : 8'h00, active, 1'(ob), 1'(ov)});
      end
   end
   // Monitor: compares DUT outputs on the falling edge against the oldest expectation.
   initial begin
      logic [13:0] e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {sel, gnt, busy, out_bit, out_valid};
            n_total++;
            if (a === e) n_pass++;
            else $display("FAIL outputs t=%0t got sel=%0d gnt=%h busy=%b bit=%b vld=%b exp sel=%0d gnt=%h busy=%b bit=%b vld=%b",
                          $time, a[13:11], a[10:3], a[2], a[1], a[0], e[13:11], e[10:3], e[2], e[1], e[0]);
         end
      end
   end
   task automatic cyc(input logic [7:0] r, input logic [7:0] d, input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
         req = r;
         din = d;
      end
   endtask
   task automatic cyc_rnd(input logic [7:0] r, input int n);
      repeat (n) cyc(r, 8'($urandom), 1);
   endtask
   initial begin
      logic [7:0] r;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      cyc(8'h01, 8'h01, 12);
      cyc(8'h00, 8'h00, 3);
      cyc_rnd(8'h81, 24);
      cyc_rnd(8'hFF, 40);
      cyc(8'h00, 8'h00, 3);
      cyc_rnd(8'h08, 3);
      cyc_rnd(8'h20, 5);
      cyc_rnd(8'h04, 3);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({sel, gnt, busy, out_bit, out_valid} === 14'h0) n_pass++;
      else $display("FAIL async_reset got sel=%0d gnt=%h busy=%b bit=%b vld=%b exp all zero",
                    sel, gnt, busy, out_bit, out_valid);
      @(negedge clk);
      #2 rst_n = 1'b1;
      cyc_rnd(8'h04, 8);
      cyc(8'h00, 8'h00, 2);
      cyc_rnd(8'h40, 2);
      cyc(8'h00, 8'h00, 3);
      cyc_rnd(8'h41, 14);
      for (int i = 0; i < 2000; i++) begin
         r = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 3) == 0) r = r | 8'($urandom);
         cyc(r, 8'($urandom), $urandom_range(1, 4));
      end
      cyc(8'h00, 8'h00, 3);
      repeat (2) @(negedge clk);
      #3;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
